// File: rtl/linear_layer_start_fifo_srl_ctrl.sv
// linear_layer_start_fifo_srl_ctrl
// Purpose : start-token FIFO built on a shift-register array, first-word-fall-through
//           read side, for start propagation between HLS dataflow processes.
// Ports   : clk/reset (sync, active-high); write side if_write_ce/if_write/if_din,
//           if_full_n; read side if_read_ce/if_read/if_dout/if_empty_n;
//           if_num_data_valid (occupancy), if_fifo_cap (constant DEPTH).
// Latency : write-to-read 1 cycle; pop frees space 1 cycle later; flags registered,
//           so there is no combinational path from request inputs to flags.
module linear_layer_start_fifo_srl_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH:0]   w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr_next;
  logic                  r_empty_n;
  logic                  r_full_n;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Accept only against the registered flags, so a write while full or a read
  // while empty is dropped without touching any state.
  assign w_wr_acc = if_write & if_write_ce & r_full_n;
  assign w_rd_acc = if_read  & if_read_ce  & r_empty_n;

  // rd_addr tracks cnt-1 (the oldest entry). On a simultaneous read+write the
  // shift brings the second-oldest token under the unchanged address.
  always_comb begin
    w_cnt_next     = r_cnt;
    w_rd_addr_next = r_rd_addr;
    if (w_wr_acc && !w_rd_acc) begin
      w_cnt_next = r_cnt + CNT_ONE;
      if (r_cnt != '0) begin
        w_rd_addr_next = r_rd_addr + ADDR_ONE;
      end
    end else if (w_rd_acc && !w_wr_acc) begin
      w_cnt_next = r_cnt - CNT_ONE;
      if (r_cnt > CNT_ONE) begin
        w_rd_addr_next = r_rd_addr - ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_empty_n <= 1'b0;
      r_full_n  <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_next;
      r_rd_addr <= w_rd_addr_next;
      r_empty_n <= (w_cnt_next != '0);
      r_full_n  <= (w_cnt_next != LP_DEPTH);
    end
  end

  // Storage is not reset; a reset write is suppressed so contents are retained.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !reset) begin
      for (int i = DEPTH-1; i > 0; i--) begin
        r_mem[i] <= r_mem[i-1];
      end
      r_mem[0] <= if_din;
    end
  end

  assign if_dout           = r_mem[r_rd_addr];
  assign if_empty_n        = r_empty_n;
  assign if_full_n         = r_full_n;
  assign if_num_data_valid = r_cnt;
  assign if_fifo_cap       = LP_DEPTH;

endmodule

// File: doc/linear_layer_start_fifo_srl_ctrl.md
Name: linear_layer_start_fifo_srl_ctrl

Overview:
- Complete start-token FIFO around shift-register (SRL) storage, for start propagation between HLS dataflow processes (e.g. into the PE_i4xi4 pack stage).
- Write side shifts tokens in at position 0; read side tracks the oldest token with an occupancy-derived address and presents it first-word-fall-through.
- Provides producer back-pressure (full_n), consumer availability (empty_n) and an occupancy count for the dataflow scheduler.

Parameters:
- DATA_WIDTH, 1, token width in bits.
- ADDR_WIDTH, 5, read-address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- DEPTH, 17, storage entries (capacity).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_write_ce  in  1  write-side clock enable; when low, writes are ignored.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  token to enqueue.
- if_full_n  out  1  high when at least one free entry exists.
- if_read_ce  in  1  read-side clock enable; when low, reads are ignored.
- if_read  in  1  consumer pop request.
- if_dout  out  DATA_WIDTH  oldest token, valid while if_empty_n=1.
- if_empty_n  out  1  high when at least one token is stored.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

Behaviour:
- Storage: DEPTH x DATA_WIDTH shift array, not reset.
  - On accepted write, every entry i moves to i+1 and if_din enters entry 0.
  - if_dout = storage[rd_addr], combinational from registered state.
- Accept conditions:
  - wr_acc = if_write & if_write_ce & if_full_n.
  - rd_acc = if_read & if_read_ce & if_empty_n.
  - A write while full and a read while empty are silently dropped; no state change.
- Occupancy register cnt (ADDR_WIDTH+1 bits) updates each edge:
  - wr_acc & !rd_acc: cnt+1.
  - rd_acc & !wr_acc: cnt-1.
  - both or neither: unchanged.
- Read address rd_addr (ADDR_WIDTH bits):
  - Equals cnt-1 whenever cnt>0.
  - Update rules:
    - wr_acc only, cnt>0: +1.
    - wr_acc only, cnt=0: stays 0.
    - rd_acc only, cnt>1: -1.
    - rd_acc only, cnt=1: stays 0.
    - Simultaneous accepted read and write: unchanged. The shift moves the second-oldest token to rd_addr, which is correct FIFO order.
  - rd_addr never wraps.
- Flags are registered, derived from next-state cnt:
  - if_empty_n = (cnt_next != 0).
  - if_full_n = (cnt_next != DEPTH).
- Latency:
  - A token written at edge t is visible on if_dout, with if_empty_n=1, after edge t (write-to-read latency 1 cycle).
  - A pop at edge t frees space with if_full_n=1 after edge t.
  - No combinational path from if_read to if_full_n, or from if_write to if_empty_n.
- Simultaneous read+write while full: the read is accepted; the write is rejected because if_full_n=0 that cycle. Result: cnt=DEPTH-1.
- Simultaneous read+write with 0<cnt<DEPTH: both accepted; cnt and flags unchanged; if_dout advances to the next token.
- Reset, including mid-operation, takes priority over writes and reads that cycle. Values after the reset edge:
  - cnt=0, rd_addr=0.
  - if_empty_n=0, if_full_n=1, if_num_data_valid=0.
  - if_dout is don't-care; storage contents are retained but unreachable.
- if_num_data_valid = cnt; if_fifo_cap = DEPTH at all times.

Test Plan:
- Reset then idle → if_empty_n=0, if_full_n=1, if_num_data_valid=0, if_fifo_cap=17; read pulses cause no change.
- With DATA_WIDTH=8, write 0x11, 0x22, 0x33 on consecutive cycles → if_empty_n rises 1 cycle after the first write, if_dout=0x11; three pops return 0x11, 0x22, 0x33; if_empty_n=0 after the third pop.
- Write 17 tokens 0x00..0x10 → if_full_n=0 after the 17th write, count=17; an 18th write of 0xFF is dropped; 17 pops return 0x00..0x10 in order, never 0xFF.
- With 5 entries, assert read+write together for 10 cycles → count stays 5, flags stable, output order is preserved across the overlap.
- With the FIFO full, read+write together → only the read is accepted, count=16, if_full_n=1 next cycle; the next write is accepted.
- With 9 entries, assert reset mid-stream while if_write=1 and if_read=1 → count=0, if_empty_n=0, if_full_n=1 after the edge; a subsequent write of 0xA5 is read back as 0xA5.
- Drive if_write_ce=0 or if_read_ce=0 with requests active → no state change.
